id_ex_stage_reg: RTL and testbench

ID/EX pipeline register for the 5-stage RISC-V core, placed directly downstream of the register file. It captures the decoded instruction and the two register-file read operands at the end of Decode and presents them to Execute. It also detects load-use hazards, drives the Fetch/Decode stall signals, inserts bubbles, honours branch flushes and external Execute holds, and counts load-use bubbles for performance monitoring.

---
 rtl/id_ex_stage_reg.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded instruction and operands for Execute,
// detects load-use hazards, drives front-end stalls and counts load-use bubbles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [XLEN-1:0]  read_data1_d,
    input  logic [XLEN-1:0]  read_data2_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic             reg_write_d,
    input  logic             mem_read_d,
    input  logic             mem_write_d,
    input  logic             alu_src_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic [3:0]       alu_ctrl_d,
    input  logic [1:0]       result_src_d,
    input  logic             flush_e,
    input  logic             hold_e,
    output logic             valid_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic             use_rs1_e,
    output logic             use_rs2_e,
    output logic [XLEN-1:0]  read_data1_e,
    output logic [XLEN-1:0]  read_data2_e,
    output logic [XLEN-1:0]  imm_e,
    output logic             reg_write_e,
    output logic             mem_read_e,
    output logic             mem_write_e,
    output logic             alu_src_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic [3:0]       alu_ctrl_e,
    output logic [1:0]       result_src_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            use_rs1;
        logic            use_rs2;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [3:0]      alu_ctrl;
        logic [1:0]      result_src;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t dec;
    logic   lu;
    logic   cnt_sat;

    // Operands always travel; control fields are gated so an invalid slot never writes state.
    always_comb begin
        dec         = '0;
        dec.valid   = valid_d;
        dec.pc      = pc_d;
        dec.rs1     = rs1_d;
        dec.rs2     = rs2_d;
        dec.rd      = rd_d;
        dec.use_rs1 = use_rs1_d;
        dec.use_rs2 = use_rs2_d;
        dec.rd1     = read_data1_d;
        dec.rd2     = read_data2_d;
        dec.imm     = imm_d;
        if (valid_d) begin
            dec.reg_write  = reg_write_d;
            dec.mem_read   = mem_read_d;
            dec.mem_write  = mem_write_d;
            dec.alu_src    = alu_src_d;
            dec.branch     = branch_d;
            dec.jump       = jump_d;
            dec.alu_ctrl   = alu_ctrl_d;
            dec.result_src = result_src_d;
        end
    end

    // Independent of flush_e on purpose; upstream masks the stall when it flushes IF/ID.
    assign lu = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & valid_d &
                ((use_rs1_d & (rs1_d == ex_q.rd)) | (use_rs2_d & (rs2_d == ex_q.rd)));

    assign stall_f = lu | hold_e;
    assign stall_d = lu | hold_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ex_q <= '0;
        else if (flush_e) ex_q <= '0;
        else if (hold_e)  ex_q <= ex_q;
        else if (lu)      ex_q <= '0;
        else              ex_q <= dec;
    end

    assign cnt_sat = &bubble_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_count <= '0;
        else if (lu && !flush_e && !hold_e && !cnt_sat)
            bubble_count <= bubble_count + CNT_W'(1);
    end

    assign valid_e      = ex_q.valid;
    assign pc_e         = ex_q.pc;
    assign rs1_e        = ex_q.rs1;
    assign rs2_e        = ex_q.rs2;
    assign rd_e         = ex_q.rd;
    assign use_rs1_e    = ex_q.use_rs1;
    assign use_rs2_e    = ex_q.use_rs2;
    assign read_data1_e = ex_q.rd1;
    assign read_data2_e = ex_q.rd2;
    assign imm_e        = ex_q.imm;
    assign reg_write_e  = ex_q.reg_write;
    assign mem_read_e   = ex_q.mem_read;
    assign mem_write_e  = ex_q.mem_write;
    assign alu_src_e    = ex_q.alu_src;
    assign branch_e     = ex_q.branch;
    assign jump_e       = ex_q.jump;
    assign alu_ctrl_e   = ex_q.alu_ctrl;
    assign result_src_e = ex_q.result_src;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed Decode vectors push expected
// Execute-side state; a monitor pops one record per cycle and compares.
module tb_id_ex_stage_reg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_d = 0, use_rs1_d = 0, use_rs2_d = 0;
    logic [XLEN-1:0] pc_d = '0, read_data1_d = '0, read_data2_d = '0, imm_d = '0;
    logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
    logic reg_write_d = 0, mem_read_d = 0, mem_write_d = 0, alu_src_d = 0, branch_d = 0, jump_d = 0;
    logic [3:0] alu_ctrl_d = '0;
    logic [1:0] result_src_d = '0;
    logic flush_e = 0, hold_e = 0;

    logic valid_e, use_rs1_e, use_rs2_e;
    logic [XLEN-1:0] pc_e, read_data1_e, read_data2_e, imm_e;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e;
    logic [3:0] alu_ctrl_e;
    logic [1:0] result_src_e;
    logic stall_f, stall_d;
    logic [CNT_W-1:0] bubble_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        int          id;
        logic        stall, valid, rw, mr, mw;
        logic [31:0] pc, d1, d2;
        logic [4:0]  rd;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sbq[$];
    int   step_id = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .pc_d(pc_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .read_data1_d(read_data1_d), .read_data2_d(read_data2_d), .imm_d(imm_d),
        .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d),
        .alu_ctrl_d(alu_ctrl_d), .result_src_d(result_src_d),
        .flush_e(flush_e), .hold_e(hold_e),
        .valid_e(valid_e), .pc_e(pc_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .use_rs1_e(use_rs1_e), .use_rs2_e(use_rs2_e),
        .read_data1_e(read_data1_e), .read_data2_e(read_data2_e), .imm_e(imm_e),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
        .alu_ctrl_e(alu_ctrl_e), .result_src_e(result_src_e),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic chk_outputs(input exp_t r);
        chk("valid_e", r.id, 32'(valid_e), 32'(r.valid));
        chk("reg_write_e", r.id, 32'(reg_write_e), 32'(r.rw));
        chk("mem_read_e", r.id, 32'(mem_read_e), 32'(r.mr));
        chk("mem_write_e", r.id, 32'(mem_write_e), 32'(r.mw));
        chk("pc_e", r.id, pc_e, r.pc);
        chk("rd_e", r.id, 32'(rd_e), 32'(r.rd));
        chk("read_data1_e", r.id, read_data1_e, r.d1);
        chk("read_data2_e", r.id, read_data2_e, r.d2);
        chk("bubble_count", r.id, 32'(bubble_count), 32'(r.cnt));
    endtask

    // Stalls are combinational: sampled mid-low-phase; registered state just after the edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                r = sbq.pop_front();
                chk("stall_f", r.id, 32'(stall_f), 32'(r.stall));
                chk("stall_d", r.id, 32'(stall_d), 32'(r.stall));
                if (r.rst) begin
                    chk_outputs(r);
                end else begin
                    @(posedge clk);
                    #1;
                    chk_outputs(r);
                end
            end
        end
    end

    task automatic set_d(input logic v, input logic [31:0] pc, input logic [4:0] r1, r2, rd,
                         input logic u1, u2, input logic [31:0] a, b, input logic rw, mr, mw);
        valid_d = v; pc_d = pc; rs1_d = r1; rs2_d = r2; rd_d = rd;
        use_rs1_d = u1; use_rs2_d = u2; read_data1_d = a; read_data2_d = b;
        reg_write_d = rw; mem_read_d = mr; mem_write_d = mw;
        imm_d = 32'h4; alu_src_d = mr | mw; alu_ctrl_d = 4'h2; result_src_d = {1'b0, mr};
    endtask

    task automatic push(input bit rst, input logic st, v, rw, mr, mw, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [31:0] a, b, input logic [3:0] cnt);
        exp_t r;
        r.rst = rst; r.id = step_id; r.stall = st; r.valid = v; r.rw = rw; r.mr = mr; r.mw = mw;
        r.pc = pc; r.rd = rd; r.d1 = a; r.d2 = b; r.cnt = cnt;
        sbq.push_back(r);
        step_id++;
    endtask

    task automatic exp_step(input logic st, v, rw, mr, mw, input logic [31:0] pc,
                            input logic [4:0] rd, input logic [31:0] a, b, input logic [3:0] cnt);
        push(0, st, v, rw, mr, mw, pc, rd, a, b, cnt);
        @(negedge clk);
    endtask

    task automatic exp_bub(input logic st, input logic [3:0] cnt);
        exp_step(st, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 32'h0, cnt);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] pc;
        @(negedge clk);
        // Reset state with Decode idle
        push(1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_d(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd7, 1, 0, 0);      // add x3,x1,x2
        exp_step(0, 1, 1, 0, 0, 32'h100, 5'd3, 32'd5, 32'd7, 4'd0);
        set_d(1, 32'h104, 5'd1, 5'd0, 5'd5, 1, 0, 32'd5, 32'd0, 1, 1, 0);      // lw x5
        exp_step(0, 1, 1, 1, 0, 32'h104, 5'd5, 32'd5, 32'd0, 4'd0);
        set_d(1, 32'h108, 5'd5, 5'd1, 5'd6, 1, 1, 32'h11, 32'd5, 1, 0, 0);     // add x6,x5,x1
        exp_bub(1, 4'd1);
        exp_step(0, 1, 1, 0, 0, 32'h108, 5'd6, 32'h11, 32'd5, 4'd1);
        set_d(1, 32'h10c, 5'd6, 5'd0, 5'd0, 1, 0, 32'h22, 32'd0, 1, 1, 0);     // lw x0
        exp_step(0, 1, 1, 1, 0, 32'h10c, 5'd0, 32'h22, 32'd0, 4'd1);
        set_d(1, 32'h110, 5'd0, 5'd0, 5'd7, 1, 1, 32'd0, 32'd0, 1, 0, 0);      // reads x0
        exp_step(0, 1, 1, 0, 0, 32'h110, 5'd7, 32'd0, 32'd0, 4'd1);
        set_d(1, 32'h114, 5'd1, 5'd0, 5'd8, 1, 0, 32'h33, 32'd0, 1, 1, 0);     // lw x8
        exp_step(0, 1, 1, 1, 0, 32'h114, 5'd8, 32'h33, 32'd0, 4'd1);
        set_d(1, 32'h118, 5'd2, 5'd8, 5'd9, 1, 0, 32'h44, 32'h55, 1, 0, 0);    // rs2 matches, unused
        exp_step(0, 1, 1, 0, 0, 32'h118, 5'd9, 32'h44, 32'h55, 4'd1);

        set_d(1, 32'h11c, 5'd1, 5'd2, 5'd0, 1, 1, 32'd1, 32'd2, 0, 0, 1);      // sw, flushed
        flush_e = 1;
        exp_bub(0, 4'd1);
        flush_e = 0;
        set_d(1, 32'h120, 5'd3, 5'd4, 5'd10, 1, 1, 32'hAA, 32'hBB, 1, 0, 0);
        exp_step(0, 1, 1, 0, 0, 32'h120, 5'd10, 32'hAA, 32'hBB, 4'd1);
        set_d(1, 32'h124, 5'd3, 5'd4, 5'd11, 1, 1, 32'hCC, 32'hDD, 1, 0, 0);   // flush beats hold
        flush_e = 1; hold_e = 1;
        exp_bub(1, 4'd1);
        flush_e = 0; hold_e = 0;

        set_d(1, 32'h128, 5'd5, 5'd6, 5'd12, 1, 1, 32'h12, 32'h34, 1, 0, 0);
        exp_step(0, 1, 1, 0, 0, 32'h128, 5'd12, 32'h12, 32'h34, 4'd1);
        hold_e = 1;
        for (int i = 0; i < 3; i++) begin
            set_d(1, 32'h12c + 32'(i * 4), 5'd7, 5'd8, 5'd20, 1, 1, 32'h900 + 32'(i), 32'h0, 0, 0, 1);
            exp_step(1, 1, 1, 0, 0, 32'h128, 5'd12, 32'h12, 32'h34, 4'd1);
        end
        hold_e = 0;
        set_d(1, 32'h138, 5'd5, 5'd6, 5'd13, 1, 1, 32'h56, 32'h78, 1, 0, 0);
        exp_step(0, 1, 1, 0, 0, 32'h138, 5'd13, 32'h56, 32'h78, 4'd1);

        set_d(1, 32'h13c, 5'd1, 5'd0, 5'd14, 1, 0, 32'd1, 32'd0, 1, 1, 0);     // lw x14
        exp_step(0, 1, 1, 1, 0, 32'h13c, 5'd14, 32'd1, 32'd0, 4'd1);
        set_d(1, 32'h140, 5'd0, 5'd14, 5'd15, 1, 1, 32'd0, 32'd9, 1, 0, 0);    // uses x14 via rs2
        hold_e = 1;                                                            // hold freezes counter
        exp_step(1, 1, 1, 1, 0, 32'h13c, 5'd14, 32'd1, 32'd0, 4'd1);
        hold_e = 0;
        exp_bub(1, 4'd2);
        exp_step(0, 1, 1, 0, 0, 32'h140, 5'd15, 32'd0, 32'd9, 4'd2);

        set_d(0, 32'h144, 5'd1, 5'd2, 5'd16, 1, 1, 32'd5, 32'd6, 1, 1, 1);     // invalid Decode
        exp_step(0, 0, 0, 0, 0, 32'h144, 5'd16, 32'd5, 32'd6, 4'd2);

        c = 4'd2;
        for (int i = 0; i < 16; i++) begin
            pc = 32'h300 + 32'(i * 8);
            set_d(1, pc, 5'd1, 5'd0, 5'd5, 1, 0, 32'(i), 32'd0, 1, 1, 0);
            exp_step(0, 1, 1, 1, 0, pc, 5'd5, 32'(i), 32'd0, c);
            set_d(1, pc + 32'd4, 5'd5, 5'd1, 5'd6, 1, 1, 32'd0, 32'(i), 1, 0, 0);
            c = (c == 4'd15) ? 4'd15 : c + 4'd1;
            exp_bub(1, c);
            exp_step(0, 1, 1, 0, 0, pc + 32'd4, 5'd6, 32'd0, 32'(i), c);
        end

        set_d(1, 32'h400, 5'd1, 5'd0, 5'd5, 1, 0, 32'd0, 32'd0, 1, 1, 0);
        exp_step(0, 1, 1, 1, 0, 32'h400, 5'd5, 32'd0, 32'd0, 4'd15);
        set_d(1, 32'h404, 5'd5, 5'd1, 5'd6, 1, 1, 32'd0, 32'd0, 1, 0, 0);     // would stall
        push(1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 32'h0, 4'd0);
        #1 rst_n = 1'b0;                                                       // async, mid-cycle
        @(negedge clk);
        rst_n = 1'b1;
        set_d(1, 32'h500, 5'd1, 5'd2, 5'd3, 1, 1, 32'd1, 32'd2, 1, 0, 0);
        exp_step(0, 1, 1, 0, 0, 32'h500, 5'd3, 32'd1, 32'd2, 4'd0);

        for (int k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
